tt_ovi_completion_merge: RTL and testbench
==========================================

// Module: tt_ovi_completion_merge
// PURPOSE
//  Merges completions from the memory-op scoreboard (loads/stores) and the vector execute unit onto the single
//  OVI completed interface. Neither source accepts backpressure; both may fire in the same cycle.
//  Buffers overflow completions, emits at most one per cycle in arrival order, registered outputs.
// PARAMETERS
//  DEPTH     8   pending-entry FIFO depth, excluding the output register; power of 2, >=2
//  SB_ID_W   5   scoreboard id width
//  DATA_W    64  scalar dest_reg width
//  FFLAGS_W  5   FP exception flags width
// PORTS
//  clk                  in   1         clock
//  reset_n              in   1         async active-low reset
//  i_mem_cmpl_valid     in   1         memop scoreboard completion strobe
//  i_mem_cmpl_sb_id     in   SB_ID_W   its sb_id
//  i_mem_cmpl_fflags    in   FFLAGS_W  its fflags
//  i_mem_cmpl_dest_reg  in   DATA_W    its scalar result
//  i_vex_cmpl_valid     in   1         vector execute completion strobe
//  i_vex_cmpl_sb_id     in   SB_ID_W   its sb_id
//  i_vex_cmpl_fflags    in   FFLAGS_W  its fflags
//  i_vex_cmpl_dest_reg  in   DATA_W    its scalar result
//  i_vex_cmpl_vxsat     in   1         fixed-point saturation flag
//  o_completed_valid    out  1         OVI completion strobe (one cycle per completion)
//  o_completed_sb_id    out  SB_ID_W
//  o_completed_fflags   out  FFLAGS_W
//  o_completed_dest_reg out  DATA_W
//  o_completed_vxsat    out  1         0 for mem-sourced completions
//  o_pending_cnt        out  $clog2(DEPTH)+1  FIFO occupancy (excl. output reg)
//  o_overflow           out  1         sticky: a completion was dropped
//  o_dup_err            out  1         sticky: both sources fired with equal sb_id
// BEHAVIOUR
//  - Reset (async, reset_n=0): all outputs 0, FIFO empty, pointers 0; takes effect mid-stream, pending dropped.
//  - Arrival order per cycle: mem entry first, then vex entry. FIFO has 2 write ports, 1 read port.
//  - Each cycle the output register loads the oldest pending item among {FIFO head, this cycle's arrivals};
//    o_completed_valid=1 iff an item was loaded, else 0 (other outputs hold last value).
//  - Latency: arrival at cycle t with FIFO empty -> o_completed_valid at t+1 (bypass, no FIFO write).
//  - Both arrive, FIFO empty: mem at t+1, vex at t+2. Sustained 2/cycle drains 1/cycle; FIFO grows by 1/cycle.
//  - Occupancy: cnt_nxt = cnt + n_arrivals - ((cnt+n_arrivals)>0). n_arrivals in {0,1,2}.
//  - Full: items with cnt_nxt>DEPTH are dropped, vex before mem; o_overflow set, held until reset.
//    Occupancy saturates at DEPTH; no wrap corruption. Pointers wrap modulo DEPTH.
//  - o_dup_err set when both valids and sb_ids equal; both entries still enqueued.
//  - Ordering guarantee: completions leave in arrival order; per-source order always preserved.
//  - No flush input: the OVI protocol never kills issued completions.
// STRUCTURE
//  - Package tt_ovi_cmpl_pkg: typedef struct packed cmpl_entry_t {sb_id, dest_reg, fflags, vxsat};
//    localparams SB_ID_W, DATA_W, FFLAGS_W shared with the memop scoreboard.
//  - Sub-module tt_cmpl_fifo_2w1r: DEPTH-entry, 2-write/1-read FIFO of cmpl_entry_t with count and full logic.
//  - Top level: arrival packing, bypass mux, output register, sticky flags.
// TESTING
//  1 Single mem completion sb_id=3, dest=0xDEAD, FIFO empty -> next cycle valid=1, sb_id=3, dest=0xDEAD, vxsat=0.
//  2 Same-cycle mem sb_id=4 + vex sb_id=9 vxsat=1 -> t+1 sb_id=4; t+2 sb_id=9 vxsat=1; cnt 1 then 0.
//  3 Both sources every cycle for 8 cycles (DEPTH=8) -> no overflow; 16 outputs in order over 16 cycles.
//  4 Both sources every cycle for 10 cycles -> o_overflow=1 at cycle 9; vex entry dropped first; cnt caps at 8.
//  5 Both valids with sb_id=7 -> o_dup_err=1; two sb_id=7 completions emitted.
//  6 Reset asserted with cnt=5 -> outputs 0 same cycle, cnt=0; after release, new completion emitted at t+1.

Source files
------------

// File: rtl/tt_ovi_cmpl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tt_ovi_cmpl_pkg : completion entry type and widths shared with the memop SB
// Revision: 1.0
// ----------------------------------------------------------------------------
package tt_ovi_cmpl_pkg;

    localparam int SB_ID_W  = 5;
    localparam int DATA_W   = 64;
    localparam int FFLAGS_W = 5;

    typedef struct packed {
        logic [SB_ID_W-1:0]  sb_id;
        logic [DATA_W-1:0]   dest_reg;
        logic [FFLAGS_W-1:0] fflags;
        logic                vxsat;
    } cmpl_entry_t;

    localparam int CMPL_ENTRY_W = $bits(cmpl_entry_t);

endpackage
`default_nettype wire

// File: rtl/tt_cmpl_fifo_2w1r.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tt_cmpl_fifo_2w1r : DEPTH-entry completion FIFO, two write ports, one read
// Revision: 1.0
// ----------------------------------------------------------------------------
module tt_cmpl_fifo_2w1r
    import tt_ovi_cmpl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_wr0_valid,
    input  logic [CMPL_ENTRY_W-1:0] i_wr0_data,
    input  logic                    i_wr1_valid,
    input  logic [CMPL_ENTRY_W-1:0] i_wr1_data,
    input  logic                    i_rd_en,
    output logic [CMPL_ENTRY_W-1:0] o_head,
    output logic [$clog2(DEPTH):0]  o_cnt,
    output logic                    o_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cmpl_entry_t      mem_q [DEPTH];
    cmpl_entry_t      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [CNT_W-1:0] w_space;
    logic [PTR_W-1:0] w_wp;
    logic             w_pop;
    logic             w_acc0;
    logic             w_acc1;

    always_comb begin
        mem_d   = mem_q;
        w_pop   = i_rd_en && (cnt_q != '0);
        // A pop this cycle frees a slot for the same-cycle writes.
        w_space = CNT_W'(DEPTH) - cnt_q + CNT_W'(w_pop);
        w_acc0  = i_wr0_valid && (w_space != '0);
        w_acc1  = i_wr1_valid && (w_space > CNT_W'(w_acc0));
        w_wp    = wr_ptr_q;
        if (w_acc0) begin
            mem_d[w_wp] = i_wr0_data;
            w_wp        = w_wp + 1'b1;
        end
        if (w_acc1) begin
            mem_d[w_wp] = i_wr1_data;
            w_wp        = w_wp + 1'b1;
        end
        wr_ptr_d = w_wp;
        rd_ptr_d = rd_ptr_q + PTR_W'(w_pop);
        cnt_d    = cnt_q + CNT_W'(w_acc0) + CNT_W'(w_acc1) - CNT_W'(w_pop);
        o_drop   = (i_wr0_valid && !w_acc0) || (i_wr1_valid && !w_acc1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_head = mem_q[rd_ptr_q];
    assign o_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/tt_ovi_completion_merge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tt_ovi_completion_merge : merges memop and vex completions onto OVI completed
// Revision: 1.0
// ----------------------------------------------------------------------------
module tt_ovi_completion_merge #(
    parameter int DEPTH    = 8,
    parameter int SB_ID_W  = tt_ovi_cmpl_pkg::SB_ID_W,
    parameter int DATA_W   = tt_ovi_cmpl_pkg::DATA_W,
    parameter int FFLAGS_W = tt_ovi_cmpl_pkg::FFLAGS_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_mem_cmpl_valid,
    input  logic [SB_ID_W-1:0]       i_mem_cmpl_sb_id,
    input  logic [FFLAGS_W-1:0]      i_mem_cmpl_fflags,
    input  logic [DATA_W-1:0]        i_mem_cmpl_dest_reg,
    input  logic                     i_vex_cmpl_valid,
    input  logic [SB_ID_W-1:0]       i_vex_cmpl_sb_id,
    input  logic [FFLAGS_W-1:0]      i_vex_cmpl_fflags,
    input  logic [DATA_W-1:0]        i_vex_cmpl_dest_reg,
    input  logic                     i_vex_cmpl_vxsat,
    output logic                     o_completed_valid,
    output logic [SB_ID_W-1:0]       o_completed_sb_id,
    output logic [FFLAGS_W-1:0]      o_completed_fflags,
    output logic [DATA_W-1:0]        o_completed_dest_reg,
    output logic                     o_completed_vxsat,
    output logic [$clog2(DEPTH):0]   o_pending_cnt,
    output logic                     o_overflow,
    output logic                     o_dup_err
);

    import tt_ovi_cmpl_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    cmpl_entry_t      w_mem_entry;
    cmpl_entry_t      w_vex_entry;
    cmpl_entry_t      w_head;
    cmpl_entry_t      w_wr0_entry;
    cmpl_entry_t      w_wr1_entry;
    logic             w_wr0_valid;
    logic             w_wr1_valid;
    logic             w_rd_en;
    logic             w_drop;
    logic [CNT_W-1:0] w_fifo_cnt;

    logic             out_valid_q;
    logic             out_valid_d;
    cmpl_entry_t      out_entry_q;
    cmpl_entry_t      out_entry_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             dup_err_q;
    logic             dup_err_d;

    always_comb begin
        w_mem_entry = '{sb_id: i_mem_cmpl_sb_id, dest_reg: i_mem_cmpl_dest_reg,
                        fflags: i_mem_cmpl_fflags, vxsat: 1'b0};
        w_vex_entry = '{sb_id: i_vex_cmpl_sb_id, dest_reg: i_vex_cmpl_dest_reg,
                        fflags: i_vex_cmpl_fflags, vxsat: i_vex_cmpl_vxsat};
    end

    // Oldest pending item goes to the output register; younger arrivals queue
    // behind the FIFO contents with mem ahead of vex.
    always_comb begin
        out_valid_d = 1'b0;
        out_entry_d = out_entry_q;
        w_rd_en     = 1'b0;
        w_wr0_valid = 1'b0;
        w_wr0_entry = w_vex_entry;
        w_wr1_valid = 1'b0;
        w_wr1_entry = w_vex_entry;
        if (w_fifo_cnt != '0) begin
            w_rd_en     = 1'b1;
            out_valid_d = 1'b1;
            out_entry_d = w_head;
            w_wr0_valid = i_mem_cmpl_valid || i_vex_cmpl_valid;
            w_wr0_entry = i_mem_cmpl_valid ? w_mem_entry : w_vex_entry;
            w_wr1_valid = i_mem_cmpl_valid && i_vex_cmpl_valid;
        end else begin
            out_valid_d = i_mem_cmpl_valid || i_vex_cmpl_valid;
            if (i_mem_cmpl_valid) begin
                out_entry_d = w_mem_entry;
            end else if (i_vex_cmpl_valid) begin
                out_entry_d = w_vex_entry;
            end
            w_wr0_valid = i_mem_cmpl_valid && i_vex_cmpl_valid;
        end
        overflow_d = overflow_q || w_drop;
        dup_err_d  = dup_err_q || (i_mem_cmpl_valid && i_vex_cmpl_valid &&
                                   (i_mem_cmpl_sb_id == i_vex_cmpl_sb_id));
    end

    tt_cmpl_fifo_2w1r #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_wr0_valid (w_wr0_valid),
        .i_wr0_data  (w_wr0_entry),
        .i_wr1_valid (w_wr1_valid),
        .i_wr1_data  (w_wr1_entry),
        .i_rd_en     (w_rd_en),
        .o_head      (w_head),
        .o_cnt       (w_fifo_cnt),
        .o_drop      (w_drop)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_entry_q <= '0;
            overflow_q  <= 1'b0;
            dup_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_entry_q <= out_entry_d;
            overflow_q  <= overflow_d;
            dup_err_q   <= dup_err_d;
        end
    end

    assign o_completed_valid    = out_valid_q;
    assign o_completed_sb_id    = out_entry_q.sb_id;
    assign o_completed_fflags   = out_entry_q.fflags;
    assign o_completed_dest_reg = out_entry_q.dest_reg;
    assign o_completed_vxsat    = out_entry_q.vxsat;
    assign o_pending_cnt        = w_fifo_cnt;
    assign o_overflow           = overflow_q;
    assign o_dup_err            = dup_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tt_ovi_completion_merge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tt_ovi_completion_merge : scoreboard bench against a queue-based model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_tt_ovi_completion_merge;
    import tt_ovi_cmpl_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        i_mem_cmpl_valid = 1'b0;
    logic [4:0]  i_mem_cmpl_sb_id = '0;
    logic [4:0]  i_mem_cmpl_fflags = '0;
    logic [63:0] i_mem_cmpl_dest_reg = '0;
    logic        i_vex_cmpl_valid = 1'b0;
    logic [4:0]  i_vex_cmpl_sb_id = '0;
    logic [4:0]  i_vex_cmpl_fflags = '0;
    logic [63:0] i_vex_cmpl_dest_reg = '0;
    logic        i_vex_cmpl_vxsat = 1'b0;
    logic        o_completed_valid;
    logic [4:0]  o_completed_sb_id;
    logic [4:0]  o_completed_fflags;
    logic [63:0] o_completed_dest_reg;
    logic        o_completed_vxsat;
    logic [3:0]  o_pending_cnt;
    logic        o_overflow;
    logic        o_dup_err;

    tt_ovi_completion_merge #(.DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .i_mem_cmpl_valid     (i_mem_cmpl_valid),
        .i_mem_cmpl_sb_id     (i_mem_cmpl_sb_id),
        .i_mem_cmpl_fflags    (i_mem_cmpl_fflags),
        .i_mem_cmpl_dest_reg  (i_mem_cmpl_dest_reg),
        .i_vex_cmpl_valid     (i_vex_cmpl_valid),
        .i_vex_cmpl_sb_id     (i_vex_cmpl_sb_id),
        .i_vex_cmpl_fflags    (i_vex_cmpl_fflags),
        .i_vex_cmpl_dest_reg  (i_vex_cmpl_dest_reg),
        .i_vex_cmpl_vxsat     (i_vex_cmpl_vxsat),
        .o_completed_valid    (o_completed_valid),
        .o_completed_sb_id    (o_completed_sb_id),
        .o_completed_fflags   (o_completed_fflags),
        .o_completed_dest_reg (o_completed_dest_reg),
        .o_completed_vxsat    (o_completed_vxsat),
        .o_pending_cnt        (o_pending_cnt),
        .o_overflow           (o_overflow),
        .o_dup_err            (o_dup_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: everything accepted but not yet emitted, oldest first.
    cmpl_entry_t m_pend[$];
    cmpl_entry_t exp_q[$];
    bit          m_out_pending = 1'b0;
    bit          m_ovf = 1'b0;
    bit          m_dup = 1'b0;

    bit          exp_valid_now = 1'b0;
    int          exp_cnt_now = 0;
    bit          exp_ovf_now = 1'b0;
    bit          exp_dup_now = 1'b0;
    bit          in_reset = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input bit mv, input logic [4:0] ms, input logic [63:0] md, input logic [4:0] mf,
                        input bit vv, input logic [4:0] vs, input logic [63:0] vd, input logic [4:0] vf,
                        input bit vx);
        cmpl_entry_t e;
        @(posedge clk);
        #1;
        exp_valid_now = m_out_pending;
        exp_cnt_now   = m_pend.size();
        exp_ovf_now   = m_ovf;
        exp_dup_now   = m_dup;
        i_mem_cmpl_valid = mv; i_mem_cmpl_sb_id = ms; i_mem_cmpl_dest_reg = md; i_mem_cmpl_fflags = mf;
        i_vex_cmpl_valid = vv; i_vex_cmpl_sb_id = vs; i_vex_cmpl_dest_reg = vd; i_vex_cmpl_fflags = vf;
        i_vex_cmpl_vxsat = vx;
        if (mv) begin
            e = '{sb_id: ms, dest_reg: md, fflags: mf, vxsat: 1'b0};
            m_pend.push_back(e);
        end
        if (vv) begin
            e = '{sb_id: vs, dest_reg: vd, fflags: vf, vxsat: vx};
            m_pend.push_back(e);
        end
        if (mv && vv && ms == vs) m_dup = 1'b1;
        m_out_pending = (m_pend.size() != 0);
        if (m_out_pending) exp_q.push_back(m_pend.pop_front());
        while (m_pend.size() > DEPTH) begin
            void'(m_pend.pop_back());
            m_ovf = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 5'd0, 64'd0, 5'd0, 1'b0, 5'd0, 64'd0, 5'd0, 1'b0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        in_reset = 1'b1;
        i_mem_cmpl_valid = 1'b0;
        i_vex_cmpl_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_valid",    64'(o_completed_valid), 64'd0);
        check("rst_sb_id",    64'(o_completed_sb_id), 64'd0);
        check("rst_dest_reg", o_completed_dest_reg, 64'd0);
        check("rst_fflags",   64'(o_completed_fflags), 64'd0);
        check("rst_vxsat",    64'(o_completed_vxsat), 64'd0);
        check("rst_cnt",      64'(o_pending_cnt), 64'd0);
        check("rst_overflow", 64'(o_overflow), 64'd0);
        check("rst_dup_err",  64'(o_dup_err), 64'd0);
        m_pend.delete();
        exp_q.delete();
        m_out_pending = 1'b0;
        m_ovf = 1'b0;
        m_dup = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        exp_valid_now = 1'b0;
        exp_cnt_now   = 0;
        exp_ovf_now   = 1'b0;
        exp_dup_now   = 1'b0;
        in_reset      = 1'b0;
    endtask

    initial begin : monitor
        cmpl_entry_t e;
        forever begin
            @(negedge clk);
            if (!in_reset) begin
                check("valid",       64'(o_completed_valid), 64'(exp_valid_now));
                check("pending_cnt", 64'(o_pending_cnt), 64'(exp_cnt_now));
                check("overflow",    64'(o_overflow), 64'(exp_ovf_now));
                check("dup_err",     64'(o_dup_err), 64'(exp_dup_now));
                if (o_completed_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_completion: got sb_id 0x%0h, required no completion",
                                 o_completed_sb_id);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_id",    64'(o_completed_sb_id), 64'(e.sb_id));
                        check("dest_reg", o_completed_dest_reg, e.dest_reg);
                        check("fflags",   64'(o_completed_fflags), 64'(e.fflags));
                        check("vxsat",    64'(o_completed_vxsat), 64'(e.vxsat));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion of stimulus");
        $fatal(1);
    end

    initial begin : stimulus
        int rate;
        apply_reset();

        // single mem completion through the bypass path
        step(1'b1, 5'd3, 64'hDEAD, 5'd0, 1'b0, 5'd0, 64'd0, 5'd0, 1'b0);
        idle(2);
        // same-cycle mem + vex
        step(1'b1, 5'd4, 64'h4444, 5'h01, 1'b1, 5'd9, 64'h9999, 5'h02, 1'b1);
        idle(3);
        // 8 cycles of dual arrivals: fills exactly to DEPTH
        for (int i = 0; i < 8; i++)
            step(1'b1, 5'(i), 64'(100 + i), 5'(i), 1'b1, 5'(i + 16), 64'(200 + i), 5'(i + 8), 1'(i));
        idle(18);
        // 10 cycles of dual arrivals: overflow, vex dropped
        for (int i = 0; i < 10; i++)
            step(1'b1, 5'(i), 64'(300 + i), 5'(i), 1'b1, 5'(i + 16), 64'(400 + i), 5'(i), 1'b1);
        idle(12);
        // duplicate sb_id
        step(1'b1, 5'd7, 64'h7A, 5'd1, 1'b1, 5'd7, 64'h7B, 5'd2, 1'b0);
        idle(3);
        // reset with five pending entries, then a fresh completion
        apply_reset();
        for (int i = 0; i < 5; i++)
            step(1'b1, 5'(i), 64'(500 + i), 5'd0, 1'b1, 5'(i + 8), 64'(600 + i), 5'd0, 1'b0);
        apply_reset();
        step(1'b0, 5'd0, 64'd0, 5'd0, 1'b1, 5'd21, 64'hCAFE, 5'd3, 1'b1);
        idle(3);

        for (int seg = 0; seg < 3; seg++) begin
            rate = (seg == 0) ? 30 : (seg == 1) ? 60 : 97;
            for (int c = 0; c < 600; c++)
                step(1'($urandom_range(0, 99) < rate), 5'($urandom), {$urandom, $urandom}, 5'($urandom),
                     1'($urandom_range(0, 99) < rate), 5'($urandom), {$urandom, $urandom}, 5'($urandom),
                     1'($urandom));
            idle(DEPTH + 4);
            if (seg == 1) apply_reset();
        end

        idle(DEPTH + 4);
        check("drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
